// File: rtl/writeback_regfile.sv
// Register file with a one-entry execute-to-writeback latch and forwarding.
// After reset the array is zeroed one register per cycle before ready rises.
module writeback_regfile #(
    parameter int WIDTH    = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] read_reg0,
    input  logic [ADDR_W-1:0] read_reg1,
    output logic [WIDTH-1:0]  read_data0,
    output logic [WIDTH-1:0]  read_data1,
    input  logic              ex_valid,
    input  logic [ADDR_W-1:0] ex_rd,
    input  logic [WIDTH-1:0]  ex_result,
    output logic              wb_valid,
    output logic [ADDR_W-1:0] wb_reg,
    output logic [WIDTH-1:0]  wb_data,
    output logic              ready
);

    localparam int NREGS = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NREGS - 1);

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] clr_cnt_q;
    logic [ADDR_W-1:0] clr_cnt_d;
    logic              ready_q;
    logic              wb_valid_q;
    logic [ADDR_W-1:0] wb_reg_q;
    logic [WIDTH-1:0]  wb_data_q;
    logic [WIDTH-1:0]  mem_q [NREGS];
    logic              commit_d;

    assign clr_cnt_d = clr_cnt_q + 1'b1;
    // Writes aimed at the hardwired zero register are dropped at commit.
    assign commit_d  = wb_valid_q && !((ZERO_REG != 0) && (wb_reg_q == '0));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= CLEAR;
            clr_cnt_q  <= '0;
            ready_q    <= 1'b0;
            wb_valid_q <= 1'b0;
            wb_reg_q   <= '0;
            wb_data_q  <= '0;
        end else begin
            case (state_q)
                CLEAR: begin
                    mem_q[clr_cnt_q] <= '0;
                    clr_cnt_q        <= clr_cnt_d;
                    wb_valid_q       <= 1'b0;
                    if (clr_cnt_q == LAST_IDX) begin
                        state_q <= RUN;
                        ready_q <= 1'b1;
                    end
                end
                RUN: begin
                    if (commit_d) begin
                        mem_q[wb_reg_q] <= wb_data_q;
                    end
                    wb_valid_q <= ex_valid;
                    wb_reg_q   <= ex_rd;
                    wb_data_q  <= ex_result;
                end
                default: state_q <= CLEAR;
            endcase
        end
    end

    // Only the latched entry is forwarded; the live ALU result never is.
    function automatic logic [WIDTH-1:0] read_port(input logic [ADDR_W-1:0] idx);
        if (!ready_q) begin
            return '0;
        end else if ((ZERO_REG != 0) && (idx == '0)) begin
            return '0;
        end else if (wb_valid_q && (wb_reg_q == idx)) begin
            return wb_data_q;
        end else begin
            return mem_q[idx];
        end
    endfunction

    assign read_data0 = read_port(read_reg0);
    assign read_data1 = read_port(read_reg1);

    assign wb_valid = wb_valid_q;
    assign wb_reg   = wb_reg_q;
    assign wb_data  = wb_data_q;
    assign ready    = ready_q;

endmodule

// File: tb/tb_writeback_regfile.sv
// Directed bench for writeback_regfile: clear sequence, forwarding, r0 handling
// and reset behaviour, with hand-computed expectations checked by assertions.
module tb_writeback_regfile;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  read_reg0 = '0;
    logic [4:0]  read_reg1 = '0;
    logic [31:0] read_data0;
    logic [31:0] read_data1;
    logic        ex_valid = 1'b0;
    logic [4:0]  ex_rd = '0;
    logic [31:0] ex_result = '0;
    logic        wb_valid;
    logic [4:0]  wb_reg;
    logic [31:0] wb_data;
    logic        ready;

    int vectors = 0;
    int miscompares = 0;

    writeback_regfile #(.WIDTH(32), .ADDR_W(5), .ZERO_REG(1)) dut (
        .clk        (clk),
        .rst        (rst),
        .read_reg0  (read_reg0),
        .read_reg1  (read_reg1),
        .read_data0 (read_data0),
        .read_data1 (read_data1),
        .ex_valid   (ex_valid),
        .ex_rd      (ex_rd),
        .ex_result  (ex_result),
        .wb_valid   (wb_valid),
        .wb_reg     (wb_reg),
        .wb_data    (wb_data),
        .ready      (ready)
    );

    always #5 clk = ~clk;

    // Advance one active edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic present(input logic v, input logic [4:0] rd, input logic [31:0] res);
        ex_valid  = v;
        ex_rd     = rd;
        ex_result = res;
    endtask

    initial begin
        // Test 1: two reset edges, then 32 clear edges.
        step();
        step();
        check("rst_ready", 32'(ready), 32'd0);
        check("rst_wb_valid", 32'(wb_valid), 32'd0);
        check("rst_wb_reg", 32'(wb_reg), 32'd0);
        check("rst_wb_data", wb_data, 32'd0);
        rst = 1'b0;
        for (int k = 1; k <= 32; k++) begin
            read_reg0 = 5'(k * 7);
            step();
            check($sformatf("clr_ready_e%0d", k), 32'(ready), (k == 32) ? 32'd1 : 32'd0);
            if (k < 32) check($sformatf("clr_read_e%0d", k), read_data0, 32'd0);
        end
        for (int r = 0; r < 32; r++) begin
            read_reg0 = 5'(r);
            #1;
            check($sformatf("cleared_r%0d", r), read_data0, 32'd0);
        end

        // Test 2: single write, forwarded then from the array.
        present(1'b1, 5'd5, 32'hDEADBEEF);
        read_reg1 = 5'd5;
        #1;
        check("live_not_fwd", read_data1, 32'd0);
        step();
        present(1'b0, 5'd5, 32'h0BADF00D);
        #1;
        check("w5_wb_valid", 32'(wb_valid), 32'd1);
        check("w5_wb_reg", 32'(wb_reg), 32'd5);
        check("w5_fwd", read_data1, 32'hDEADBEEF);
        step();
        check("w5_wb_idle", 32'(wb_valid), 32'd0);
        check("w5_array", read_data1, 32'hDEADBEEF);

        // Test 3: back-to-back writes to r7; both ports read r7.
        read_reg0 = 5'd7;
        read_reg1 = 5'd7;
        present(1'b1, 5'd7, 32'h11);
        step();
        present(1'b1, 5'd7, 32'h22);
        #1;
        check("r7_first", read_data0, 32'h11);
        check("r7_first_p1", read_data1, 32'h11);
        step();
        present(1'b0, 5'd0, 32'h0);
        #1;
        check("r7_fwd_newest", read_data0, 32'h22);
        check("r7_fwd_newest_p1", read_data1, 32'h22);
        step();
        check("r7_array", read_data0, 32'h22);
        step();
        check("r7_array_hold", read_data1, 32'h22);

        // Test 4: write to r0 is latched but never visible.
        read_reg0 = 5'd0;
        read_reg1 = 5'd0;
        present(1'b1, 5'd0, 32'hFFFFFFFF);
        #1;
        check("r0_pre", read_data0, 32'd0);
        step();
        present(1'b0, 5'd0, 32'h0);
        #1;
        check("r0_wb_valid", 32'(wb_valid), 32'd1);
        check("r0_wb_reg", 32'(wb_reg), 32'd0);
        check("r0_wb_data", wb_data, 32'hFFFFFFFF);
        check("r0_fwd_blocked", read_data0, 32'd0);
        check("r0_fwd_blocked_p1", read_data1, 32'd0);
        step();
        check("r0_after_commit", read_data0, 32'd0);

        // Test 5: r9 in array, pending r9 write discarded by reset.
        read_reg1 = 5'd9;
        present(1'b1, 5'd9, 32'h1234);
        step();
        present(1'b0, 5'd0, 32'h0);
        step();
        check("r9_array", read_data1, 32'h1234);
        present(1'b1, 5'd9, 32'hAAAA);
        step();
        present(1'b0, 5'd0, 32'h0);
        #1;
        check("r9_pending_fwd", read_data1, 32'hAAAA);
        rst = 1'b1;
        step();
        check("r9_rst_wb_valid", 32'(wb_valid), 32'd0);
        check("r9_rst_wb_data", wb_data, 32'd0);
        check("r9_rst_ready", 32'(ready), 32'd0);
        check("r9_rst_read", read_data1, 32'd0);

        // Test 6: writes ignored during clear; rst at clear edge 10 restarts it.
        rst = 1'b0;
        present(1'b1, 5'd3, 32'h55);
        for (int k = 1; k <= 9; k++) begin
            step();
            check($sformatf("c6_wb_valid_e%0d", k), 32'(wb_valid), 32'd0);
            check($sformatf("c6_ready_e%0d", k), 32'(ready), 32'd0);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int k = 1; k <= 32; k++) begin
            step();
            check($sformatf("c6_restart_ready_e%0d", k), 32'(ready), (k == 32) ? 32'd1 : 32'd0);
            check($sformatf("c6_restart_wb_e%0d", k), 32'(wb_valid), 32'd0);
        end
        present(1'b0, 5'd0, 32'h0);
        read_reg0 = 5'd3;
        read_reg1 = 5'd9;
        #1;
        check("r3_after_ready", read_data0, 32'd0);
        check("r9_after_clear", read_data1, 32'd0);
        step();
        check("r3_wb_idle", 32'(wb_valid), 32'd0);
        check("r3_still_zero", read_data0, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
